io_mem_bridge: RTL and testbench

//   Bus master for the IO port of the dual-port data RAM. Streams bytes from a byte source
//   (e.g. UART RX) into consecutive RAM words (LOAD), or reads consecutive RAM words back out
//   as a byte stream (DUMP). Used for program/data loading and memory dump while the CPU runs
//   on the other port. Words are packed and unpacked little-endian: byte 0 maps to [7:0].

---
 rtl/io_mem_bridge.sv | 165 ++++++++++++++++
 tb/tb_io_mem_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mem_bridge.sv
// rtl/io_mem_bridge.sv - byte-stream LOAD/DUMP master for the RAM IO port
module io_mem_bridge #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_load,
  input  logic                     start_dump,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic                     wEn_io,
  output logic [ADDRESS_WIDTH-1:0] addr_io,
  output logic [DATA_WIDTH-1:0]    dataIn_io,
  input  logic [DATA_WIDTH-1:0]    dataOut_io,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_BYTE, S_LD_WRITE, S_DP_REQ, S_DP_CAP, S_DP_SEND, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic [ADDRESS_WIDTH:0]   word_idx_q, word_idx_d;
  logic [1:0]               byte_idx_q, byte_idx_d;
  logic [23:0]              asm_q, asm_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    tx_word_q, tx_word_d;
  logic [ADDRESS_WIDTH:0]   word_inc;
  logic                     last_word;
  logic                     aborting;

  assign word_inc  = word_idx_q + 1'b1;
  assign last_word = (word_inc == count_q);
  assign aborting  = abort && (state_q != S_IDLE);

  assign busy      = (state_q != S_IDLE);
  assign addr_io   = base_q + word_idx_q[ADDRESS_WIDTH-1:0];
  assign dataIn_io = wdata_q;

  always_comb begin
    case (byte_idx_q)
      2'd0:    tx_data = tx_word_q[7:0];
      2'd1:    tx_data = tx_word_q[15:8];
      2'd2:    tx_data = tx_word_q[23:16];
      default: tx_data = tx_word_q[31:24];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wdata_d    = wdata_q;
    tx_word_d  = tx_word_q;
    rx_ready   = 1'b0;
    tx_valid   = 1'b0;
    wEn_io     = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_load || start_dump) begin
          base_d     = base_addr;
          count_d    = word_count;
          word_idx_d = '0;
          byte_idx_d = '0;
          if (word_count == '0)  state_d = S_DONE;
          else if (start_load)   state_d = S_LD_BYTE;
          else                   state_d = S_DP_REQ;
        end
      end
      S_LD_BYTE: begin
        rx_ready = !abort;
        if (rx_valid) begin
          // The 4th byte goes straight into the write register so it is ready for LD_WRITE
          if (byte_idx_q == 2'd3) begin
            wdata_d    = {rx_data, asm_q};
            byte_idx_d = '0;
            state_d    = S_LD_WRITE;
          end else begin
            case (byte_idx_q)
              2'd0:    asm_d[7:0]   = rx_data;
              2'd1:    asm_d[15:8]  = rx_data;
              default: asm_d[23:16] = rx_data;
            endcase
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_LD_WRITE: begin
        wEn_io     = !abort;
        word_idx_d = word_inc;
        state_d    = last_word ? S_DONE : S_LD_BYTE;
      end
      S_DP_REQ: state_d = S_DP_CAP;
      S_DP_CAP: begin
        tx_word_d = dataOut_io;
        state_d   = S_DP_SEND;
      end
      S_DP_SEND: begin
        tx_valid = !abort;
        if (tx_ready) begin
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = '0;
            word_idx_d = word_inc;
            state_d    = last_word ? S_DONE : S_DP_REQ;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any same-cycle handshake: counters and write data are left untouched
    if (aborting) begin
      state_d    = S_IDLE;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      wdata_d    = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      wdata_q    <= '0;
      tx_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wdata_q    <= wdata_d;
      tx_word_q  <= tx_word_d;
    end
  end

endmodule

// File: tb/tb_io_mem_bridge.sv
// tb/tb_io_mem_bridge.sv - directed self-checking bench for io_mem_bridge
module tb_io_mem_bridge;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset, start_load, start_dump, abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          rx_valid, rx_ready, tx_valid, tx_ready, wEn_io, busy, done;
  logic [7:0]    rx_data, tx_data;
  logic [AW-1:0] addr_io;
  logic [31:0]   dataIn_io, dataOut_io;

  always #5 clk = ~clk;

  io_mem_bridge #(.DATA_WIDTH(32), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_dump(start_dump),
    .abort(abort), .base_addr(base_addr), .word_count(word_count),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .wEn_io(wEn_io), .addr_io(addr_io), .dataIn_io(dataIn_io),
    .dataOut_io(dataOut_io), .busy(busy), .done(done)
  );

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (wEn_io) mem[addr_io] <= dataIn_io;
    dataOut_io <= mem[addr_io];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt, done_cnt, rdy_cnt, txv_cnt, rdy_in_wr;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  always @(negedge clk) begin
    if (wEn_io) begin
      wr_addr.push_back(addr_io);
      wr_data.push_back(dataIn_io);
      wr_cnt++;
      if (rx_ready) rdy_in_wr++;
    end
    if (done)     done_cnt++;
    if (rx_ready) rdy_cnt++;
    if (tx_valid) txv_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clr;
    wr_cnt = 0; done_cnt = 0; rdy_cnt = 0; txv_cnt = 0; rdy_in_wr = 0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic start(input bit ld, input bit dp, input logic [AW-1:0] b, input logic [AW:0] c);
    base_addr = b; word_count = c; start_load = ld; start_dump = dp;
    tick;
    start_load = 0; start_dump = 0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok;
    ok = 0;
    rx_valid = 1; rx_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rx_ready) ok = 1;
      tick;
    end
    rx_valid = 0;
    check_eq("rx_handshake", ok, 1);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input string tag);
    bit ok;
    logic [7:0] held;
    ok = 0;
    tx_ready = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (tx_valid) ok = 1;
      else tick;
    end
    check_eq({tag, "_valid"}, ok, 1);
    held = tx_data;
    tick;
    check_eq({tag, "_stall_stable"}, tx_data, held);
    tx_ready = 1;
    check_eq(tag, tx_data, exp);
    tick;
    tx_ready = 0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (done) ok = 1;
      else tick;
    end
    check_eq(tag, ok, 1);
    check_eq({tag, "_busy"}, busy, 1);
    tick;
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    reset = 1; start_load = 0; start_dump = 0; abort = 0;
    base_addr = '0; word_count = '0; rx_valid = 0; rx_data = '0; tx_ready = 0;
    tick; tick;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rx_ready", rx_ready, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_wen", wEn_io, 0);
    check_eq("rst_addr", addr_io, 0);
    check_eq("rst_din", dataIn_io, 0);
    check_eq("rst_tx_data", tx_data, 0);
    reset = 0;
    tick;

    // T1: two-word load
    clr;
    start(1, 0, 14'h010, 2);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_done("t1_done");
    check_eq("t1_wr_cnt", wr_cnt, 2);
    if (wr_addr.size() >= 2) begin
      check_eq("t1_addr0", wr_addr[0], 32'h010);
      check_eq("t1_data0", wr_data[0], 32'h12345678);
      check_eq("t1_addr1", wr_addr[1], 32'h011);
      check_eq("t1_data1", wr_data[1], 32'hDEADBEEF);
    end
    check_eq("t1_rdy_in_wr", rdy_in_wr, 0);
    check_eq("t1_done_cnt", done_cnt, 1);

    // T2: one-word dump with stalls
    clr;
    mem[16] = 32'h12345678;
    start(0, 1, 14'h010, 1);
    recv_byte(8'h78, "t2_b0");
    recv_byte(8'h56, "t2_b1");
    recv_byte(8'h34, "t2_b2");
    recv_byte(8'h12, "t2_b3");
    wait_done("t2_done");
    check_eq("t2_no_write", wr_cnt, 0);
    check_eq("t2_done_cnt", done_cnt, 1);

    // T3: address wrap
    clr;
    start(1, 0, 14'h3FFF, 2);
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
    wait_done("t3_done");
    check_eq("t3_wr_cnt", wr_cnt, 2);
    if (wr_addr.size() >= 2) begin
      check_eq("t3_addr0", wr_addr[0], 32'h3FFF);
      check_eq("t3_data0", wr_data[0], 32'h14131211);
      check_eq("t3_addr1", wr_addr[1], 32'h0000);
      check_eq("t3_data1", wr_data[1], 32'h18171615);
    end

    // T4: zero-length transfer
    clr;
    start(1, 0, 14'h100, 0);
    check_eq("t4_done", done, 1);
    check_eq("t4_busy", busy, 1);
    check_eq("t4_rx_ready", rx_ready, 0);
    check_eq("t4_tx_valid", tx_valid, 0);
    check_eq("t4_wen", wEn_io, 0);
    tick;
    check_eq("t4_idle", busy, 0);
    check_eq("t4_rdy_cnt", rdy_cnt, 0);
    check_eq("t4_wr_cnt", wr_cnt, 0);
    check_eq("t4_txv_cnt", txv_cnt, 0);

    // T5: abort after two bytes, then a clean load
    clr;
    start(1, 0, 14'h020, 1);
    send_byte(8'hAA); send_byte(8'hBB);
    rx_valid = 1; rx_data = 8'hCC; abort = 1;
    tick;
    abort = 0; rx_valid = 0;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_rx_ready", rx_ready, 0);
    check_eq("t5_done", done, 0);
    tick; tick;
    check_eq("t5_no_write", wr_cnt, 0);
    check_eq("t5_no_done", done_cnt, 0);
    start(1, 0, 14'h020, 1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done("t5_done2");
    check_eq("t5_wr_cnt", wr_cnt, 1);
    if (wr_addr.size() >= 1) begin
      check_eq("t5_addr", wr_addr[0], 32'h020);
      check_eq("t5_data", wr_data[0], 32'h04030201);
    end

    // T6: reset during DP_SEND, then both starts high
    clr;
    start(0, 1, 14'h010, 1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (tx_valid) ok = 1;
      else tick;
    end
    check_eq("t6_in_send", ok, 1);
    reset = 1;
    tick;
    check_eq("t6_tx_valid", tx_valid, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_done", done, 0);
    reset = 0;
    clr;
    start(1, 1, 14'h030, 1);
    check_eq("t6_load_rdy", rx_ready, 1);
    check_eq("t6_load_txv", tx_valid, 0);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    wait_done("t6_done2");
    check_eq("t6_wr_cnt", wr_cnt, 1);
    if (wr_addr.size() >= 1) begin
      check_eq("t6_addr", wr_addr[0], 32'h030);
      check_eq("t6_data", wr_data[0], 32'h01020304);
    end
    check_eq("t6_txv_cnt", txv_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
